// File: rtl/qos_pop_scheduler_pkg.sv
// rtl/qos_pop_scheduler_pkg.sv - shared constants, state encoding and weight helper for the QoS pop scheduler
package qos_pop_scheduler_pkg;

    localparam int NUM_VC = 4;
    localparam int VC_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } sched_state_t;

    localparam logic [3:0] DEF_W0 = 4'd4;
    localparam logic [3:0] DEF_W1 = 4'd3;
    localparam logic [3:0] DEF_W2 = 4'd2;
    localparam logic [3:0] DEF_W3 = 4'd1;

    // A zero weight would give a burst with no credit; serve at least one word.
    function automatic logic [3:0] eff_weight(input logic [3:0] w);
        return (w == 4'd0) ? 4'd1 : w;
    endfunction

endpackage

// File: rtl/qos_pop_scheduler_if.sv
// rtl/qos_pop_scheduler_if.sv - FIFO-status / pop-strobe bundle between the scheduler and its VC FIFOs and sink
//   EMPTY_IN, ALMOST_FULL_IN : per-VC FIFO flags
//   DOWN_FULL                : sink back-pressure
//   POP                      : combinational one-hot read strobe
//   VALID_OUT, SEL_OUT       : registered data-valid and source VC (FIFO read latency 1)
//   BURST_DONE               : registered end-of-burst pulse
interface qos_pop_scheduler_if;
    import qos_pop_scheduler_pkg::*;

    logic [NUM_VC-1:0] EMPTY_IN;
    logic [NUM_VC-1:0] ALMOST_FULL_IN;
    logic              DOWN_FULL;
    logic [NUM_VC-1:0] POP;
    logic              VALID_OUT;
    logic [VC_W-1:0]   SEL_OUT;
    logic              BURST_DONE;

    // master: the scheduler issuing pops
    modport master (
        input  EMPTY_IN, ALMOST_FULL_IN, DOWN_FULL,
        output POP, VALID_OUT, SEL_OUT, BURST_DONE
    );

    // slave: the FIFO bank and downstream sink
    modport slave (
        output EMPTY_IN, ALMOST_FULL_IN, DOWN_FULL,
        input  POP, VALID_OUT, SEL_OUT, BURST_DONE
    );

endinterface

// File: rtl/qos_pop_scheduler_rr_pick.sv
// rtl/qos_pop_scheduler_rr_pick.sv - combinational VC selector: almost-full priority, else rotating find-first
//   empty, almost_full : per-VC FIFO flags
//   cur                : last served VC (rotation origin)
//   found              : at least one VC is non-empty
//   pick               : selected VC index
module rr_pick
    import qos_pop_scheduler_pkg::*;
(
    input  logic [NUM_VC-1:0] empty,
    input  logic [NUM_VC-1:0] almost_full,
    input  logic [VC_W-1:0]   cur,
    output logic              found,
    output logic [VC_W-1:0]   pick
);

    logic [NUM_VC-1:0] urgent;
    logic              urgent_found;
    logic [VC_W-1:0]   urgent_idx;
    logic [VC_W-1:0]   rr_idx;
    logic [VC_W-1:0]   cand;

    always_comb begin
        urgent       = almost_full & ~empty;
        urgent_found = 1'b0;
        urgent_idx   = '0;
        rr_idx       = cur;
        cand         = cur;

        // Scan high to low so the lowest urgent index is the last one written.
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            if (urgent[i]) begin
                urgent_found = 1'b1;
                urgent_idx   = VC_W'(i);
            end
        end

        // Offsets NUM_VC..1 wrap in VC_W bits, so offset NUM_VC lands on cur itself;
        // scanning down leaves the nearest non-empty VC after cur as the winner.
        for (int k = NUM_VC; k >= 1; k--) begin
            cand = cur + VC_W'(k);
            if (!empty[cand]) begin
                rr_idx = cand;
            end
        end

        found = |(~empty);
        pick  = urgent_found ? urgent_idx : rr_idx;
    end

endmodule

// File: rtl/qos_pop_scheduler.sv
// rtl/qos_pop_scheduler.sv - weighted-burst QoS pop scheduler over four VC FIFOs
//   clk, reset_L : clock and synchronous active-low reset
//   bus          : qos_pop_scheduler_if.master (FIFO flags in, POP/VALID_OUT/SEL_OUT/BURST_DONE out)
//   W0..W3       : per-VC burst weights (0 behaves as 1)
module qos_pop_scheduler
    import qos_pop_scheduler_pkg::*;
#(
    parameter logic [3:0] W0 = DEF_W0,
    parameter logic [3:0] W1 = DEF_W1,
    parameter logic [3:0] W2 = DEF_W2,
    parameter logic [3:0] W3 = DEF_W3
) (
    input  logic                clk,
    input  logic                reset_L,
    qos_pop_scheduler_if.master bus
);

    sched_state_t      state, state_nxt;
    logic [VC_W-1:0]   cur, cur_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [NUM_VC-1:0] pop;
    logic              burst_end;

    logic              pick_found;
    logic [VC_W-1:0]   pick_idx;
    logic [3:0]        pick_weight;

    logic              valid_q;
    logic [VC_W-1:0]   sel_q;
    logic              done_q;

    rr_pick u_rr_pick (
        .empty       (bus.EMPTY_IN),
        .almost_full (bus.ALMOST_FULL_IN),
        .cur         (cur),
        .found       (pick_found),
        .pick        (pick_idx)
    );

    always_comb begin
        pick_weight = eff_weight(W0);
        case (pick_idx)
            2'd1:    pick_weight = eff_weight(W1);
            2'd2:    pick_weight = eff_weight(W2);
            2'd3:    pick_weight = eff_weight(W3);
            default: pick_weight = eff_weight(W0);
        endcase
    end

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        cnt_nxt   = cnt;
        pop       = '0;
        burst_end = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    cur_nxt   = pick_idx;
                    cnt_nxt   = pick_weight;
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                // Back-pressure freezes everything; only an unstalled cycle can pop or end.
                if (!bus.DOWN_FULL) begin
                    if (bus.EMPTY_IN[cur]) begin
                        burst_end = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        pop[cur] = 1'b1;
                        cnt_nxt  = cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            burst_end = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // The reset cycle must not consume a FIFO word even if a burst was in flight.
        if (!reset_L) begin
            pop = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state   <= ST_IDLE;
            cur     <= 2'd3;
            cnt     <= 4'd0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cur     <= cur_nxt;
            cnt     <= cnt_nxt;
            valid_q <= |pop;
            if (|pop) begin
                sel_q <= cur;
            end
            done_q  <= burst_end;
        end
    end

    assign bus.POP        = pop;
    assign bus.VALID_OUT  = valid_q;
    assign bus.SEL_OUT    = sel_q;
    assign bus.BURST_DONE = done_q;

endmodule

// File: tb/tb_qos_pop_scheduler.sv
// tb/tb_qos_pop_scheduler.sv - scoreboard bench for qos_pop_scheduler against a FIFO-occupancy reference model
module tb_qos_pop_scheduler;

    logic clk = 1'b0;
    logic reset_L;
    always #5 clk = ~clk;

    qos_pop_scheduler_if bus ();

    qos_pop_scheduler dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    localparam int WT [4] = '{4, 3, 2, 1};

    int checks   = 0;
    int failures = 0;

    // stimulus state: FIFO occupancies and control knobs
    int       fcnt [4];
    logic [3:0] af;
    logic     df;
    logic     rst_v;

    // reference model
    bit  m_burst = 1'b0;
    int  m_cur   = 3;
    int  m_left  = 0;
    bit  e_valid = 1'b0;
    bit  e_done  = 1'b0;
    int  e_sel   = 0;
    int  exp_q [$];
    int  seen [$];
    bit  mon_en  = 1'b1;
    int  mon_s;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int choose();
        for (int i = 0; i < 4; i++)
            if (af[i] && fcnt[i] > 0) return i;
        for (int k = 1; k <= 4; k++)
            if (fcnt[(m_cur + k) % 4] > 0) return (m_cur + k) % 4;
        return m_cur;
    endfunction

    function automatic int exp_pop();
        if (!reset_L || !m_burst || df || fcnt[m_cur] == 0) return 0;
        return 1 << m_cur;
    endfunction

    task automatic model_update(input int ep);
        int pv;
        if (!reset_L) begin
            m_burst = 1'b0; m_cur = 3; m_left = 0;
            e_valid = 1'b0; e_sel = 0; e_done = 1'b0;
        end else begin
            pv      = m_cur;
            e_done  = 1'b0;
            e_valid = (ep != 0);
            if (ep != 0) begin
                e_sel = pv;
                exp_q.push_back(pv);
            end
            if (!m_burst) begin
                if (fcnt[0] > 0 || fcnt[1] > 0 || fcnt[2] > 0 || fcnt[3] > 0) begin
                    m_cur   = choose();
                    m_left  = (WT[m_cur] == 0) ? 1 : WT[m_cur];
                    m_burst = 1'b1;
                end
            end else if (!df) begin
                if (fcnt[m_cur] == 0) begin
                    m_burst = 1'b0; e_done = 1'b1;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_burst = 1'b0; e_done = 1'b1;
                    end
                end
            end
            if (ep != 0) fcnt[pv]--;
        end
    endtask

    // one clock: drive inputs after the edge, check POP at the falling edge, advance model at the rising edge
    task automatic cycle();
        int ep;
        #1;
        reset_L = rst_v;
        for (int i = 0; i < 4; i++) bus.EMPTY_IN[i] = (fcnt[i] == 0);
        bus.ALMOST_FULL_IN = af;
        bus.DOWN_FULL      = df;
        @(negedge clk);
        ep = exp_pop();
        chk("pop", int'(bus.POP), ep);
        for (int i = 0; i < 4; i++) if (bus.POP[i]) seen.push_back(i);
        @(posedge clk);
        model_update(ep);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic fill(input int a, input int b, input int c, input int d);
        fcnt[0] = a; fcnt[1] = b; fcnt[2] = c; fcnt[3] = d;
    endtask

    task automatic chk_seen(input string name, input int idx, input int exp);
        if (seen.size() > idx) chk(name, seen[idx], exp);
        else                   chk(name, -1, exp);
    endtask

    // monitor: registered outputs against model, and SEL_OUT against the scoreboard queue
    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid_out", int'(bus.VALID_OUT), int'(e_valid));
            chk("burst_done", int'(bus.BURST_DONE), int'(e_done));
            chk("sel_out", int'(bus.SEL_OUT), e_sel);
            if (bus.VALID_OUT) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sel_queue actual=valid_with_no_expected required=empty t=%0t", $time);
                end else begin
                    mon_s = exp_q.pop_front();
                    chk("sel_sb", int'(bus.SEL_OUT), mon_s);
                end
            end
        end
    end

    initial begin
        int exp_seq [$];
        reset_L = 1'b0;
        rst_v   = 1'b0;
        af      = '0;
        df      = 1'b0;
        fill(0, 0, 0, 0);
        bus.EMPTY_IN       = '1;
        bus.ALMOST_FULL_IN = '0;
        bus.DOWN_FULL      = 1'b0;

        run(2);
        rst_v = 1'b1;
        run(10);

        // weighted round robin over four full VCs, two rounds
        fill(20, 20, 20, 20);
        seen.delete();
        run(28);
        for (int r = 0; r < 2; r++)
            for (int v = 0; v < 4; v++)
                for (int j = 0; j < WT[v]; j++) exp_seq.push_back(v);
        chk("rr_count", seen.size(), 20);
        for (int i = 0; i < exp_seq.size(); i++) chk_seen("rr_order", i, exp_seq[i]);

        // short VC0 burst ends on empty, then rotation moves to VC1
        fill(2, 0, 0, 0);
        seen.delete();
        run(6);
        chk("short_pops", seen.size(), 2);
        fcnt[1] = 3;
        seen.delete();
        run(6);
        chk_seen("after_empty_next", 0, 1);

        // back-pressure mid-burst on VC1
        fill(0, 0, 0, 0);
        run(3);
        fcnt[1] = 10;
        seen.delete();
        run(2);
        df = 1'b1;
        run(3);
        df = 1'b0;
        run(3);
        chk("stall_pops", seen.size(), 3);

        // almost-full arrives during a VC0 burst
        fill(0, 0, 0, 0);
        run(3);
        fcnt[0] = 10;
        run(1);
        fcnt[1] = 10; fcnt[2] = 10; fcnt[3] = 10;
        af = 4'b0100;
        seen.delete();
        run(10);
        chk_seen("af_no_preempt", 3, 0);
        chk_seen("af_next_vc2", 4, 2);
        af = '0;

        // reset in the middle of a VC3 burst
        fill(0, 0, 0, 0);
        run(3);
        fcnt[3] = 5;
        run(1);
        rst_v = 1'b0;
        run(1);
        fill(10, 10, 10, 10);
        rst_v = 1'b1;
        seen.delete();
        run(3);
        chk_seen("post_reset_vc0", 0, 0);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int v = 0; v < 4; v++)
                if ($urandom_range(0, 3) == 0) begin
                    fcnt[v] = fcnt[v] + int'($urandom_range(0, 5));
                    if (fcnt[v] > 15) fcnt[v] = 15;
                end
            af    = 4'($urandom & $urandom & $urandom);
            df    = ($urandom_range(0, 4) == 0);
            rst_v = ($urandom_range(0, 99) != 0);
            cycle();
        end

        rst_v = 1'b1;
        af    = '0;
        df    = 1'b0;
        fill(0, 0, 0, 0);
        run(3);
        chk("sb_drain", exp_q.size(), 0);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qos_pop_scheduler.md
QOS_POP_SCHEDULER -- requirements
Module: qos_pop_scheduler

Interface
REQ-001 Parameter W0, default 4, burst weight of VC0 (4-bit, 1..15).
REQ-002 Parameter W1, default 3, burst weight of VC1.
REQ-003 Parameter W2, default 2, burst weight of VC2.
REQ-004 Parameter W3, default 1, burst weight of VC3.
REQ-005 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 Port reset_L  input  1  synchronous, active-low reset.
REQ-007 Port EMPTY_IN  input  4  bit i = EMPTY flag of VC FIFO i.
REQ-008 Port ALMOST_FULL_IN  input  4  bit i = ALMOST_FULL flag of VC FIFO i.
REQ-009 Port DOWN_FULL  input  1  downstream sink cannot accept a word this cycle.
REQ-010 Port POP  output  4  one-hot or zero read strobe to VC FIFOs; combinational.
REQ-011 Port VALID_OUT  output  1  registered; high one cycle after any POP bit (FIFO read latency 1).
REQ-012 Port SEL_OUT  output  2  registered; index of VC popped in previous cycle, valid with VALID_OUT.
REQ-013 Port BURST_DONE  output  1  registered one-cycle pulse when a burst ends.

Function
REQ-014 The block SHALL implement two states, IDLE and BURST, with internal pointer CUR[1:0] and credit counter CNT[3:0].
REQ-015 In IDLE, POP SHALL be 4'b0000.
REQ-016 In IDLE, if any EMPTY_IN bit is 0, the block SHALL select a VC, set CUR to it, load CNT with its weight, and enter BURST next cycle; otherwise stay IDLE.
REQ-017 Selection SHALL give priority to the lowest-index VC with ALMOST_FULL_IN=1 and EMPTY_IN=0.
REQ-018 Without such a VC, selection SHALL be round-robin: first non-empty VC searching CUR+1, CUR+2, CUR+3, CUR (mod 4).
REQ-019 A weight parameter of 0 SHALL be treated as 1.
REQ-020 In BURST, POP[CUR] SHALL be 1 exactly when EMPTY_IN[CUR]=0 and DOWN_FULL=0; all other POP bits 0.
REQ-021 Each cycle POP is nonzero, CNT SHALL decrement by 1.
REQ-022 DOWN_FULL=1 in BURST SHALL stall: no POP, CNT and CUR held, state held.
REQ-023 BURST SHALL end, returning to IDLE next cycle, when a pop occurs with CNT=1, or when EMPTY_IN[CUR]=1 and DOWN_FULL=0.
REQ-024 BURST_DONE SHALL pulse the cycle after a burst ends; CUR SHALL retain the last served VC.
REQ-025 Consecutive bursts SHALL be separated by exactly one IDLE cycle.
REQ-026 ALMOST_FULL_IN changes during BURST SHALL NOT preempt the current burst.
REQ-027 VALID_OUT and SEL_OUT SHALL register (|POP) and the popped index every cycle; SEL_OUT holds when VALID_OUT is 0.

Reset
REQ-028 While reset_L=0 at a rising edge: state=IDLE, CUR=3, CNT=0, VALID_OUT=0, SEL_OUT=0, BURST_DONE=0.
REQ-029 POP SHALL be 0 whenever reset_L=0, including mid-burst; no pop SHALL occur in the cycle reset is sampled.
REQ-030 With CUR=3 after reset, the first round-robin search SHALL start at VC0.

Structure
REQ-031 A shared package SHALL hold NUM_VC=4, the state encoding, and default weights 4/3/2/1.
REQ-032 One combinational sub-module rr_pick SHALL compute selection (almost-full priority, rotating find-first) from EMPTY_IN, ALMOST_FULL_IN, CUR.

Verification
REQ-033 Reset, all FIFOs empty for 10 cycles -> POP=0, VALID_OUT=0, state IDLE throughout.
REQ-034 All four VCs hold 20 words, no almost-full, DOWN_FULL=0 -> pop counts 4,3,2,1 in order VC0..VC3, one idle cycle between bursts, pattern repeats.
REQ-035 VC0 holds 2 words, W0=4 -> two pops of VC0, burst ends on EMPTY, BURST_DONE pulses, next selection is VC1.
REQ-036 DOWN_FULL=1 for 3 cycles mid-burst of VC1 -> POP=0 those cycles, CNT held, remaining pops resume after release.
REQ-037 During VC0 burst, ALMOST_FULL_IN[2]=1 with VC1..VC3 non-empty -> VC0 burst completes, VC2 selected next.
REQ-038 reset_L=0 asserted mid-burst of VC3 -> POP=0 immediately, next cycle all outputs at reset values, first post-reset grant is VC0.
